// File: rtl/ads5296_align_ctrl.sv
// ads5296_align_ctrl
// Frame-clock alignment and link-training controller for one ADS5296 lane
// group in the lclk_d4 domain. It pulses the ISERDES bitslip until the 4-bit
// frame clock follows the legal 5-word frame sequence. It then syncs
// ads5296_unit and checks that the unit's fclk error counter stays static.
// While locked it watches for alignment loss and retrains on its own.
//
// Ports:
//   lclk_d4       in   1  line clock / 4 (only clock)
//   rst_n         in   1  asynchronous active-low reset
//   train         in   1  single-cycle (re)training request
//   fclk4b        in   4  deserialized frame clock word
//   fclk_err_cnt  in  32  fclk error count from ads5296_unit
//   bitslip       out  1  one-cycle ISERDES bitslip pulse
//   sync          out  1  one-cycle sync pulse to ads5296_unit
//   locked        out  1  alignment achieved and verified
//   fail          out  1  slips exhausted or verify failed
//   slip_total    out  4  bitslips issued in the current attempt
//   relock_cnt    out 16  loss-of-lock events since reset (saturating)
//   state         out  3  FSM state, for debug
module ads5296_align_ctrl #(
  parameter int unsigned CHECK_LEN     = 64,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned VERIFY_LEN    = 256,
  parameter int unsigned MAX_SLIPS     = 8,
  parameter int unsigned LOSS_THRESH   = 4
) (
  input  logic        lclk_d4,
  input  logic        rst_n,
  input  logic        train,
  input  logic [3:0]  fclk4b,
  input  logic [31:0] fclk_err_cnt,
  output logic        bitslip,
  output logic        sync,
  output logic        locked,
  output logic        fail,
  output logic [3:0]  slip_total,
  output logic [15:0] relock_cnt,
  output logic [2:0]  state
);

  localparam int unsigned WW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned GW = $clog2(CHECK_LEN + 1);
  localparam int unsigned VW = $clog2(VERIFY_LEN + 1);
  localparam int unsigned CW = $clog2(LOSS_THRESH + 1);

  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] CHECK_LAST  = GW'(CHECK_LEN - 1);
  localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_LEN - 1);
  localparam logic [3:0]    SLIP_LIMIT  = 4'(MAX_SLIPS);
  localparam logic [CW:0]   LOSS_LIMIT  = (CW+1)'(LOSS_THRESH);

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SYNC   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_LOCKED = 3'd5,
    ST_FAIL   = 3'd6
  } state_t;

  state_t      r_state, w_state_n;
  logic [3:0]  r_f, r_ff;
  logic [31:0] r_err, r_snap, w_snap_n;
  logic [WW-1:0] r_wait, w_wait_n;
  logic [GW-1:0] r_good, w_good_n;
  logic [VW-1:0] r_vcnt, w_vcnt_n;
  logic [GW-1:0] r_win, w_win_n;
  logic [CW-1:0] r_viol, w_viol_n;
  logic [CW:0]   w_viol_sum;
  logic        r_post, w_post_n;
  logic        r_bitslip, w_bitslip_n;
  logic        r_sync, w_sync_n;
  logic        r_locked, w_locked_n;
  logic        r_fail, w_fail_n;
  logic [3:0]  r_slip, w_slip_n;
  logic [15:0] r_relock, w_relock_n;
  logic        w_legal;
  logic [3:0]  w_exp;
  logic        w_good;

  // Legal successor of the previous frame-clock word
  always_comb begin
    w_legal = 1'b1;
    w_exp   = 4'b0000;
    case (r_ff)
      4'b1111: w_exp = 4'b0001;
      4'b0001: w_exp = 4'b1100;
      4'b1100: w_exp = 4'b0111;
      4'b0111: w_exp = 4'b0000;
      4'b0000: w_exp = 4'b1111;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_good = w_legal && (r_f == w_exp);

  always_comb begin
    w_state_n   = r_state;
    w_snap_n    = r_snap;
    w_wait_n    = r_wait;
    w_good_n    = r_good;
    w_vcnt_n    = r_vcnt;
    w_win_n     = r_win;
    w_viol_n    = r_viol;
    w_post_n    = r_post;
    w_bitslip_n = 1'b0;
    w_sync_n    = 1'b0;
    w_locked_n  = r_locked;
    w_fail_n    = r_fail;
    w_slip_n    = r_slip;
    w_relock_n  = r_relock;
    // The count restarts at a window wrap, and the wrap-cycle violation is
    // counted in the new window.
    w_viol_sum  = ((r_win == CHECK_LAST) ? '0 : {1'b0, r_viol}) +
                  {{CW{1'b0}}, ~w_good};

    case (r_state)
      ST_SETTLE: begin
        if (r_wait == SETTLE_LAST) begin
          w_wait_n  = '0;
          w_good_n  = '0;
          w_vcnt_n  = '0;
          w_post_n  = 1'b0;
          w_state_n = r_post ? ST_VERIFY : ST_CHECK;
        end else begin
          w_wait_n = r_wait + 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_good) begin
          if (r_good == CHECK_LAST) begin
            w_state_n = ST_SYNC;
            w_sync_n  = 1'b1;
          end else begin
            w_good_n = r_good + 1'b1;
          end
        end else if (r_slip == SLIP_LIMIT) begin
          w_state_n = ST_FAIL;
          w_fail_n  = 1'b1;
        end else begin
          // Pulse and count are registered on entry, so the pulse is exactly
          // the one cycle spent in SLIP.
          w_state_n   = ST_SLIP;
          w_bitslip_n = 1'b1;
          w_slip_n    = (r_slip == 4'hF) ? r_slip : r_slip + 4'd1;
        end
      end
      ST_SLIP: begin
        w_state_n = ST_SETTLE;
        w_wait_n  = '0;
      end
      ST_SYNC: begin
        w_snap_n  = r_err;
        w_post_n  = 1'b1;
        w_wait_n  = '0;
        w_state_n = ST_SETTLE;
      end
      ST_VERIFY: begin
        if (r_err != r_snap) begin
          w_state_n = ST_FAIL;
          w_fail_n  = 1'b1;
        end else if (r_vcnt == VERIFY_LAST) begin
          w_state_n  = ST_LOCKED;
          w_locked_n = 1'b1;
          w_win_n    = '0;
          w_viol_n   = '0;
        end else begin
          w_vcnt_n = r_vcnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        w_win_n = (r_win == CHECK_LAST) ? '0 : r_win + 1'b1;
        if (w_viol_sum >= LOSS_LIMIT) begin
          w_state_n  = ST_SETTLE;
          w_locked_n = 1'b0;
          w_relock_n = (r_relock == 16'hFFFF) ? r_relock : r_relock + 16'd1;
          w_slip_n   = '0;
          w_wait_n   = '0;
          w_post_n   = 1'b0;
          w_viol_n   = '0;
        end else begin
          w_viol_n = w_viol_sum[CW-1:0];
        end
      end
      ST_FAIL: begin
        w_fail_n   = 1'b1;
        w_locked_n = 1'b0;
      end
      default: begin
        w_state_n = ST_SETTLE;
        w_wait_n  = '0;
      end
    endcase

    if (train) begin
      w_state_n   = ST_SETTLE;
      w_wait_n    = '0;
      w_post_n    = 1'b0;
      w_locked_n  = 1'b0;
      w_fail_n    = 1'b0;
      w_slip_n    = '0;
      w_bitslip_n = 1'b0;
      w_sync_n    = 1'b0;
      w_relock_n  = r_relock;
    end
  end

  always_ff @(posedge lclk_d4 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SETTLE;
      r_f       <= '0;
      r_ff      <= '0;
      r_err     <= '0;
      r_snap    <= '0;
      r_wait    <= '0;
      r_good    <= '0;
      r_vcnt    <= '0;
      r_win     <= '0;
      r_viol    <= '0;
      r_post    <= 1'b0;
      r_bitslip <= 1'b0;
      r_sync    <= 1'b0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
      r_slip    <= '0;
      r_relock  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_f       <= fclk4b;
      r_ff      <= r_f;
      r_err     <= fclk_err_cnt;
      r_snap    <= w_snap_n;
      r_wait    <= w_wait_n;
      r_good    <= w_good_n;
      r_vcnt    <= w_vcnt_n;
      r_win     <= w_win_n;
      r_viol    <= w_viol_n;
      r_post    <= w_post_n;
      r_bitslip <= w_bitslip_n;
      r_sync    <= w_sync_n;
      r_locked  <= w_locked_n;
      r_fail    <= w_fail_n;
      r_slip    <= w_slip_n;
      r_relock  <= w_relock_n;
    end
  end

  assign bitslip    = r_bitslip;
  assign sync       = r_sync;
  assign locked     = r_locked;
  assign fail       = r_fail;
  assign slip_total = r_slip;
  assign relock_cnt = r_relock;
  assign state      = r_state;

endmodule

// File: tb/tb_ads5296_align_ctrl.sv
// tb_ads5296_align_ctrl
// Self-checking bench for ads5296_align_ctrl. An ISERDES model produces the
// 20-bit frame pattern as 4-bit words at a bit offset, and each observed
// bitslip advances that offset by one bit. Violations are injected as word
// phase jumps, one violation each. Expected values come from the frame
// pattern arithmetic and the documented timing rules.
module tb_ads5296_align_ctrl;

  localparam int unsigned CHECK_LEN   = 64;
  localparam int unsigned SETTLE      = 8;
  localparam int unsigned VERIFY_LEN  = 256;
  localparam int unsigned MAX_SLIPS   = 8;
  localparam int unsigned LOSS_THRESH = 4;
  localparam logic [19:0] PAT = 20'b1111_0001_1100_0111_0000;

  logic        lclk_d4 = 1'b0;
  logic        rst_n;
  logic        train;
  logic [3:0]  fclk4b;
  logic [31:0] fclk_err_cnt;
  logic        bitslip, sync, locked, fail;
  logic [3:0]  slip_total;
  logic [15:0] relock_cnt;
  logic [2:0]  state;

  ads5296_align_ctrl #(
    .CHECK_LEN(CHECK_LEN),
    .SETTLE_CYCLES(SETTLE),
    .VERIFY_LEN(VERIFY_LEN),
    .MAX_SLIPS(MAX_SLIPS),
    .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .lclk_d4(lclk_d4),
    .rst_n(rst_n),
    .train(train),
    .fclk4b(fclk4b),
    .fclk_err_cnt(fclk_err_cnt),
    .bitslip(bitslip),
    .sync(sync),
    .locked(locked),
    .fail(fail),
    .slip_total(slip_total),
    .relock_cnt(relock_cnt),
    .state(state)
  );

  always #5 lclk_d4 = ~lclk_d4;

  int n_checks, n_fail;
  int off, wi, n_bs, n_sync, gap, mon_err, lock_phase, exp_relock;
  bit const_mode, jump, prev_pulse, prev_lk, saw_lock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] word_at(input int p);
    logic [19:0] pt;
    logic [3:0]  w;
    pt = PAT;
    for (int j = 0; j < 4; j++) w[3-j] = pt[19 - ((p + j) % 20)];
    return w;
  endfunction

  // One cycle: observe outputs at the falling edge, then drive the next word.
  task automatic tick();
    @(negedge lclk_d4);
    if (bitslip && sync) mon_err++;
    if ((bitslip || sync) && prev_pulse) mon_err++;
    if (bitslip) begin
      if (gap < int'(SETTLE)) mon_err++;
      gap = 0;
      n_bs++;
    end else if (gap < 1000) begin
      gap++;
    end
    if (sync) n_sync++;
    if (locked) saw_lock = 1'b1;
    lock_phase = (locked && !prev_lk) ? 0 : lock_phase + 1;
    prev_pulse = bitslip || sync;
    prev_lk    = locked;
    if (bitslip) off = (off + 1) % 20;
    wi   = (wi + (jump ? 3 : 1)) % 5;
    jump = 1'b0;
    fclk4b = const_mode ? 4'b0101 : word_at(off + 4 * wi);
  endtask

  task automatic do_train();
    train = 1'b1;
    tick();
    train = 1'b0;
  endtask

  // kind 0: locked, 1: state == s, 2: bitslip
  task automatic wait_for(input int kind, input logic [2:0] s, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      case (kind)
        0:       ok = locked;
        1:       ok = (state == s);
        default: ok = bitslip;
      endcase
    end
  endtask

  task automatic wait_phase(input int target, output bit ok);
    int i;
    i = 0;
    while (lock_phase != target && i < 1000) begin
      tick();
      i++;
    end
    ok = (lock_phase == target);
  endtask

  initial begin
    bit ok, all_ok;
    int base, need, d;

    n_checks = 0; n_fail = 0;
    off = 0; wi = 0; n_bs = 0; n_sync = 0; gap = 1000; mon_err = 0;
    lock_phase = 0; exp_relock = 0;
    const_mode = 0; jump = 0; prev_pulse = 0; prev_lk = 0; saw_lock = 0;
    rst_n = 1'b0; train = 1'b0; fclk_err_cnt = 32'h10;
    fclk4b = word_at(0);

    repeat (3) tick();
    check("rst_bitslip", 32'(bitslip), 0);
    check("rst_sync", 32'(sync), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_slip_total", 32'(slip_total), 0);
    check("rst_relock", 32'(relock_cnt), 0);
    check("rst_state", 32'(state), 0);

    // Aligned stream: lock exactly SETTLE + CHECK + SYNC + SETTLE + VERIFY cycles in
    rst_n = 1'b1;
    n_bs = 0; n_sync = 0;
    repeat (SETTLE + CHECK_LEN + 1 + SETTLE + VERIFY_LEN - 1) tick();
    check("lock_early", 32'(locked), 0);
    tick();
    check("lock_time", 32'(locked), 1);
    check("lock_state", 32'(state), 5);
    check("lock_bitslips", 32'(n_bs), 0);
    check("lock_syncs", 32'(n_sync), 1);

    // LOCKED_THRESH-1 violations per window must never drop lock
    all_ok = 1'b1;
    base = $urandom_range(12, 30);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < int'(LOSS_THRESH) - 1; j++) begin
        wait_phase(64 * k + base + 3 * j, ok);
        all_ok &= ok;
        jump = 1'b1;
      end
    end
    wait_phase(64 * 3 + 5, ok);
    all_ok &= ok;
    check("sub_thresh_phase", 32'(all_ok), 1);
    check("sub_thresh_locked", 32'(locked), 1);
    check("sub_thresh_relock", 32'(relock_cnt), 32'(exp_relock));

    // LOSS_THRESH violations inside one window declare loss of lock
    all_ok = 1'b1;
    for (int j = 0; j < int'(LOSS_THRESH); j++) begin
      wait_phase(64 * 3 + base + 3 * j, ok);
      all_ok &= ok;
      jump = 1'b1;
    end
    exp_relock++;
    repeat (3) tick();
    check("loss_phase", 32'(all_ok), 1);
    check("loss_locked", 32'(locked), 0);
    check("loss_relock", 32'(relock_cnt), 32'(exp_relock));
    check("loss_slip_total", 32'(slip_total), 0);
    check("loss_state", 32'(state), 0);
    wait_for(0, 3'd0, 1000, ok);
    check("relock", 32'(ok), 1);

    // train coincident with the final violation wins: no relock event
    all_ok = 1'b1;
    base = $urandom_range(12, 30);
    for (int j = 0; j < int'(LOSS_THRESH); j++) begin
      wait_phase(base + 3 * j, ok);
      all_ok &= ok;
      jump = 1'b1;
    end
    tick();  // jump word driven
    tick();  // jump word now in the first register stage
    train = 1'b1;
    tick();
    train = 1'b0;
    check("prio_phase", 32'(all_ok), 1);
    check("prio_relock", 32'(relock_cnt), 32'(exp_relock));
    check("prio_state", 32'(state), 0);
    check("prio_locked", 32'(locked), 0);

    // ISERDES needing 1..3 bitslips from a random word phase
    for (int it = 0; it < 3; it++) begin
      need = it + 1;
      off  = (4 * $urandom_range(0, 4) + 4 - need) % 20;
      n_bs = 0;
      do_train();
      wait_for(0, 3'd0, 3000, ok);
      check("slip_lock", 32'(ok), 1);
      check("slip_total", 32'(slip_total), 32'(need));
      check("slip_pulses", 32'(n_bs), 32'(need));
    end

    // Error counter change during VERIFY; second pass uses the 32-bit wrap
    for (int it = 0; it < 2; it++) begin
      fclk_err_cnt = (it == 0) ? 32'h10 : 32'hFFFF_FFFF;
      do_train();
      saw_lock = 1'b0;
      wait_for(1, 3'd4, 1000, ok);
      check("verify_reach", 32'(ok), 1);
      d = (it == 0) ? 100 : $urandom_range(20, 200);
      repeat (d) tick();
      fclk_err_cnt = fclk_err_cnt + 32'd1;
      repeat (4) tick();
      check("verify_fail", 32'(fail), 1);
      check("verify_state", 32'(state), 6);
      check("verify_no_lock", 32'(saw_lock), 0);
    end

    // Unalignable stream exhausts MAX_SLIPS
    const_mode = 1'b1;
    n_bs = 0;
    do_train();
    wait_for(1, 3'd6, 2000, ok);
    check("exhaust_reach", 32'(ok), 1);
    check("exhaust_pulses", 32'(n_bs), 32'(MAX_SLIPS));
    check("exhaust_slip_total", 32'(slip_total), 32'(MAX_SLIPS));
    check("exhaust_fail", 32'(fail), 1);
    check("exhaust_locked", 32'(locked), 0);
    do_train();
    check("restart_slip_total", 32'(slip_total), 0);
    check("restart_fail", 32'(fail), 0);
    check("restart_state", 32'(state), 0);

    check("pulse_rules", 32'(mon_err), 0);

    // Asynchronous reset in the middle of a bitslip pulse
    wait_for(2, 3'd0, 200, ok);
    check("midslip_reach", 32'(ok), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_bitslip", 32'(bitslip), 0);
    check("arst_sync", 32'(sync), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_fail", 32'(fail), 0);
    check("arst_slip_total", 32'(slip_total), 0);
    check("arst_relock", 32'(relock_cnt), 0);
    check("arst_state", 32'(state), 0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ads5296_align_ctrl.md
Name: ads5296_align_ctrl

Overview:
- Frame-clock alignment and link-training controller for one ADS5296 deserializer lane group, running in the lclk_d4 domain.
- Observes the 4-bit deserialized frame clock and issues ISERDES bitslip pulses until the expected 20-bit frame pattern is found.
- Then pulses sync to ads5296_unit and verifies that the unit's fclk error counter stays static.
- While locked, monitors for alignment loss and retrains automatically.

Parameters:
- CHECK_LEN, 64: consecutive legal fclk4b transitions required to pass CHECK; also the LOCKED monitor window length.
- SETTLE_CYCLES, 8: wait after reset, train or bitslip before evaluating fclk4b.
- VERIFY_LEN, 256: cycles fclk_err_cnt must stay constant after sync.
- MAX_SLIPS, 8: total bitslips allowed per training attempt before FAIL.
- LOSS_THRESH, 4: violations within one CHECK_LEN window in LOCKED that declare loss of lock.

Ports:
- lclk_d4, input, 1: line clock / 4; the only clock.
- rst_n, input, 1: asynchronous, active-low reset.
- train, input, 1: single-cycle (re)training request.
- fclk4b, input, 4: deserialized frame clock, same sample as the data path.
- fclk_err_cnt, input, 32: error count from ads5296_unit.
- bitslip, output, 1: one-cycle pulse to the ISERDES Bitslip pins.
- sync, output, 1: one-cycle pulse to ads5296_unit sync.
- locked, output, 1: alignment achieved and verified.
- fail, output, 1: training exhausted MAX_SLIPS or failed verify.
- slip_total, output, 4: bitslips issued in the current attempt.
- relock_cnt, output, 16: loss-of-lock events since reset; saturates at 0xFFFF.
- state, output, 3: encoded FSM state, for debug.

Behaviour:
- Reset values: all outputs 0; state = SETTLE; internal counters 0.
- Legal successor function nxt():
  - 1111 -> 0001
  - 0001 -> 1100
  - 1100 -> 0111
  - 0111 -> 0000
  - 0000 -> 1111
- fclk4b is registered once as f_r, with previous value f_rr. A cycle is "good" iff f_rr is one of the five codes and f_r == nxt(f_rr). Any other case is a violation.
- FSM encodings: SETTLE=0, CHECK=1, SLIP=2, SYNC=3, VERIFY=4, LOCKED=5, FAIL=6.
- SETTLE:
  - Wait counter runs SETTLE_CYCLES cycles, then go to CHECK with good_cnt = 0.
- CHECK:
  - A good cycle increments good_cnt.
  - When good_cnt reaches CHECK_LEN, go to SYNC.
  - On a violation: if slip_total == MAX_SLIPS, go to FAIL; otherwise go to SLIP.
- SLIP:
  - bitslip = 1 for exactly one cycle; slip_total increments (saturating); then go to SETTLE.
- SYNC:
  - sync = 1 for exactly one cycle.
  - The registered fclk_err_cnt value captured in this cycle becomes the snapshot.
  - Then go to SETTLE-like wait (SETTLE_CYCLES) and proceed directly to VERIFY.
- VERIFY:
  - Counts VERIFY_LEN cycles.
  - If fclk_err_cnt != snapshot in any cycle: fail = 1, go to FAIL.
  - On completion: locked = 1, go to LOCKED.
- LOCKED:
  - A free-running window counter of CHECK_LEN cycles counts violations.
  - Violations reaching LOSS_THRESH within one window: locked = 0 next cycle, relock_cnt increments, slip_total clears, go to SETTLE.
  - Violation count clears at every window wrap; a violation in the wrap cycle counts into the new window.
- FAIL:
  - fail = 1, locked = 0; the FSM holds here until train.
- train:
  - Honoured in every state.
  - Next cycle: state = SETTLE; locked, fail and slip_total clear; bitslip and sync are 0; relock_cnt is unchanged.
  - train takes priority over a simultaneous loss-of-lock, slip or verify failure.
- fclk_err_cnt wrap from 0xFFFFFFFF to 0 counts as a change (failure).
- bitslip and sync are never asserted in the same cycle, and never in consecutive cycles.
- Asynchronous reset mid-operation returns everything to reset values immediately; no pulse may be truncated to a glitch.

Test Plan:
- Reset, then feed the correct 5-word fclk cycle continuously with err_cnt fixed at 0x10. Required: 0 bitslips, one sync pulse, locked = 1 after SETTLE + CHECK_LEN + SYNC + SETTLE + VERIFY_LEN cycles.
- Model ISERDES needing 3 slips (pattern rotated 1 bit per bitslip). Required: slip_total = 3, each bitslip pulse 1 cycle wide and ≥ SETTLE_CYCLES apart, then locked = 1.
- Constant fclk4b = 0101. Required: 8 bitslips, then fail = 1, state = 6; a train pulse restarts with slip_total = 0.
- Increment err_cnt 100 cycles into VERIFY. Required: fail = 1, locked stays 0.
- While LOCKED, inject 4 illegal words within 64 cycles. Required: locked falls, relock_cnt = 1, retraining relocks. Injecting 3 violations per window never drops lock.
- Assert train in the same cycle as the 4th LOCKED violation. Required: relock_cnt unchanged, state = SETTLE. Assert rst_n low mid-SLIP: bitslip = 0 immediately and all outputs return to 0.
